// File: rtl/abs_neg_pkg.sv
// Shared types and constants for the conditional-negation datapath.
package abs_neg_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_NEG  = 2'd1,
    OP_ABS  = 2'd2,
    OP_NABS = 2'd3
  } op_e;

  localparam int MAX_WIDTH = 64;

  // Most-negative two's-complement value of a given width, LSB-aligned in a wide word.
  function automatic logic [MAX_WIDTH-1:0] min_neg(input int width);
    min_neg = 64'd1 << (width - 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] max_pos(input int width);
    max_pos = min_neg(width) - 64'd1;
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Combinational A / -A / |A| / -|A| with prefix-AND increment and optional clamp.
// Zero latency, no flow control: purely a function of a_i and op_i.
module cond_negate
  import abs_neg_pkg::*;
#(
  parameter int Width    = 8,
  parameter int Speed    = 1,
  parameter bit Saturate = 1'b0
) (
  input  logic [Width-1:0] a_i,
  input  logic [1:0]       op_i,
  output logic [Width-1:0] z_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int Levels = $clog2(Width);
  localparam logic [Width-1:0] MIN_NEG = Width'(min_neg(Width));
  localparam logic [Width-1:0] MAX_POS = Width'(max_pos(Width));

  op_e              w_op;
  logic             w_neg;
  logic [Width-1:0] w_inv;
  logic [Width-1:0] w_pre;
  logic [Width-1:0] w_carry;
  logic [Width-1:0] w_sum;

  assign w_op = op_e'(op_i);

  always_comb begin
    w_neg = 1'b0;
    case (w_op)
      OP_PASS: w_neg = 1'b0;
      OP_NEG:  w_neg = 1'b1;
      OP_ABS:  w_neg = a_i[Width-1];
      OP_NABS: w_neg = ~a_i[Width-1] & (a_i != '0);
      default: w_neg = 1'b0;
    endcase
  end

  assign w_inv = a_i ^ {Width{w_neg}};

  // w_pre[i] = &w_inv[i:0]; in-place updates never read a bit written in the same level.
  always_comb begin
    w_pre = w_inv;
    if (Speed == 0) begin
      for (int i = 1; i < Width; i++) w_pre[i] = w_pre[i] & w_pre[i-1];
    end else if (Speed == 1) begin
      for (int l = 0; l < Levels; l++)
        for (int i = 0; i < Width; i++)
          if (((i + 1) % (2 << l)) == 0) w_pre[i] = w_pre[i] & w_pre[i - (1 << l)];
      for (int l = Levels - 1; l >= 0; l--)
        for (int i = 0; i < Width; i++)
          if (i >= (2 << l) && ((i + 1) % (2 << l)) == (1 << l))
            w_pre[i] = w_pre[i] & w_pre[i - (1 << l)];
    end else begin
      for (int l = 0; l < Levels; l++)
        for (int i = 0; i < Width; i++)
          if (((i >> l) & 1) == 1) w_pre[i] = w_pre[i] & w_pre[((i >> l) << l) - 1];
    end
  end

  assign w_carry = {w_pre[Width-2:0] & {(Width-1){w_neg}}, w_neg};
  assign w_sum   = w_inv ^ w_carry;
  assign ovf_o   = w_neg & (a_i == MIN_NEG);

  always_comb begin
    z_o = w_sum;
    if (Saturate && ovf_o) z_o = MAX_POS;
  end

  assign zero_o = (z_o == '0);

endmodule

// File: rtl/abs_neg_pipe.sv
// Streaming conditional negation; Stages register slices delay {z, ovf, zero}, 0 = combinational.
// Latency Stages cycles; full-rate backpressure, ready ripples combinationally from out_ready_i.
module abs_neg_pipe
  import abs_neg_pkg::*;
#(
  parameter int Width    = 8,
  parameter int Speed    = 1,
  parameter int Stages   = 1,
  parameter bit Saturate = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] a_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] z_o,
  output logic             ovf_o,
  output logic             zero_o
);

  typedef struct packed {
    logic [Width-1:0] z;
    logic             ovf;
    logic             zero;
  } payload_t;

  logic [Width-1:0] w_z;
  logic             w_ovf;
  logic             w_zero;
  payload_t         w_pay;

  cond_negate #(
    .Width   (Width),
    .Speed   (Speed),
    .Saturate(Saturate)
  ) u_cond_negate (
    .a_i   (a_i),
    .op_i  (op_i),
    .z_o   (w_z),
    .ovf_o (w_ovf),
    .zero_o(w_zero)
  );

  assign w_pay = '{z: w_z, ovf: w_ovf, zero: w_zero};

  if (Stages == 0) begin : g_comb
    assign in_ready_o          = out_ready_i;
    assign out_valid_o         = in_valid_i;
    assign {z_o, ovf_o, zero_o} = w_pay;
  end else begin : g_regs
    logic [Stages-1:0] r_vld;
    payload_t          r_pay     [Stages];
    logic [Stages:0]   w_rdy;
    logic [Stages-1:0] w_src_vld;
    payload_t          w_src_pay [Stages];

    // An empty stage always accepts, so bubbles collapse under a downstream stall.
    always_comb begin
      w_rdy[Stages] = out_ready_i;
      for (int k = Stages - 1; k >= 0; k--) w_rdy[k] = ~r_vld[k] | w_rdy[k+1];
      w_src_vld[0] = in_valid_i;
      w_src_pay[0] = w_pay;
      for (int k = 1; k < Stages; k++) begin
        w_src_vld[k] = r_vld[k-1];
        w_src_pay[k] = r_pay[k-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_vld <= '0;
        for (int k = 0; k < Stages; k++) r_pay[k] <= '0;
      end else begin
        for (int k = 0; k < Stages; k++) begin
          if (w_rdy[k]) begin
            r_vld[k] <= w_src_vld[k];
            if (w_src_vld[k]) r_pay[k] <= w_src_pay[k];
          end
        end
      end
    end

    assign in_ready_o           = w_rdy[0];
    assign out_valid_o          = r_vld[Stages-1];
    assign {z_o, ovf_o, zero_o} = r_pay[Stages-1];
  end

endmodule

// File: tb/tb_abs_neg_pipe.sv
// Bench for abs_neg_pipe: directed handshake, overflow and reset cases plus a
// scoreboarded random sweep over widths, prefix structures and pipeline depths.
module tb_abs_neg_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic zero, input logic ovf, input logic [12:0] z);
    return {1'b0, zero, ovf, z};
  endfunction

  // Reference: signed integer arithmetic, overflow when the true result leaves the range.
  function automatic logic [15:0] model(input int w, input bit sat, input logic [1:0] op,
                                        input logic [12:0] a);
    int sa, r, mask;
    logic ovf;
    mask = (1 << w) - 1;
    sa   = 32'(a) & mask;
    if (sa >= (1 << (w - 1))) sa = sa - (1 << w);
    case (op)
      2'd0:    r = sa;
      2'd1:    r = -sa;
      2'd2:    r = (sa < 0) ? -sa : sa;
      default: r = (sa > 0) ? -sa : sa;
    endcase
    ovf = (r == (1 << (w - 1)));
    if (ovf && sat) r = (1 << (w - 1)) - 1;
    r = r & mask;
    return pk(r == 0, ovf, 13'(r));
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Group A: Width 8, Stages 1, wrap (a1) and saturate (a2), shared stimulus.
  logic       a_vld, a_ordy;
  logic [1:0] a_op;
  logic [7:0] a_a;
  logic       a1_irdy, a1_ovld, a1_ovf, a1_zero, a2_irdy, a2_ovld, a2_ovf, a2_zero;
  logic [7:0] a1_z, a2_z;
  logic [15:0] q_a1[$];
  logic [15:0] q_a2[$];

  abs_neg_pipe #(.Width(8), .Speed(1), .Stages(1), .Saturate(1'b0)) u_a1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_vld), .in_ready_o(a1_irdy), .op_i(a_op),
    .a_i(a_a), .out_valid_o(a1_ovld), .out_ready_i(a_ordy), .z_o(a1_z), .ovf_o(a1_ovf),
    .zero_o(a1_zero));
  abs_neg_pipe #(.Width(8), .Speed(1), .Stages(1), .Saturate(1'b1)) u_a2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_vld), .in_ready_o(a2_irdy), .op_i(a_op),
    .a_i(a_a), .out_valid_o(a2_ovld), .out_ready_i(a_ordy), .z_o(a2_z), .ovf_o(a2_ovf),
    .zero_o(a2_zero));

  // Group B: Stages 3, Sklansky, backpressure.
  logic       b_vld, b_ordy, b_irdy, b_ovld, b_ovf, b_zero;
  logic [1:0] b_op;
  logic [7:0] b_a, b_z;
  logic [15:0] q_b[$];
  int         b_nout = 0;

  abs_neg_pipe #(.Width(8), .Speed(2), .Stages(3), .Saturate(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_vld), .in_ready_o(b_irdy), .op_i(b_op),
    .a_i(b_a), .out_valid_o(b_ovld), .out_ready_i(b_ordy), .z_o(b_z), .ovf_o(b_ovf),
    .zero_o(b_zero));

  // Group C: Width 8, serial, Stages 2 (reset and random). Group D: Width 13, Brent-Kung, Stages 2.
  logic        c_vld, c_ordy, c_irdy, c_ovld, c_ovf, c_zero;
  logic [1:0]  c_op;
  logic [7:0]  c_a, c_z;
  logic [15:0] q_c[$];
  int          c_nout = 0;
  logic        d_vld, d_ordy, d_irdy, d_ovld, d_ovf, d_zero;
  logic [1:0]  d_op;
  logic [12:0] d_a, d_z;
  logic [15:0] q_d[$];

  abs_neg_pipe #(.Width(8), .Speed(0), .Stages(2), .Saturate(1'b0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(c_vld), .in_ready_o(c_irdy), .op_i(c_op),
    .a_i(c_a), .out_valid_o(c_ovld), .out_ready_i(c_ordy), .z_o(c_z), .ovf_o(c_ovf),
    .zero_o(c_zero));
  abs_neg_pipe #(.Width(13), .Speed(1), .Stages(2), .Saturate(1'b0)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(d_vld), .in_ready_o(d_irdy), .op_i(d_op),
    .a_i(d_a), .out_valid_o(d_ovld), .out_ready_i(d_ordy), .z_o(d_z), .ovf_o(d_ovf),
    .zero_o(d_zero));

  // Group E: combinational (Stages 0) instances, all three prefix structures.
  logic        e_vld, e_ordy;
  logic [1:0]  e4_op, e13_op;
  logic [3:0]  e4_a;
  logic [12:0] e13_a;
  logic [3:0]  e4_z [4];
  logic        e4_ovf [4], e4_zero [4], e4_ovld [4], e4_irdy [4];
  logic [12:0] e13_z [3];
  logic        e13_ovf [3], e13_zero [3], e13_ovld [3], e13_irdy [3];

  for (genvar g = 0; g < 4; g++) begin : g_w4
    abs_neg_pipe #(.Width(4), .Speed(g % 3), .Stages(0), .Saturate(g == 3)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(e_vld), .in_ready_o(e4_irdy[g]), .op_i(e4_op),
      .a_i(e4_a), .out_valid_o(e4_ovld[g]), .out_ready_i(e_ordy), .z_o(e4_z[g]),
      .ovf_o(e4_ovf[g]), .zero_o(e4_zero[g]));
  end
  for (genvar g = 0; g < 3; g++) begin : g_w13
    abs_neg_pipe #(.Width(13), .Speed(g), .Stages(0), .Saturate(1'b0)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(e_vld), .in_ready_o(e13_irdy[g]), .op_i(e13_op),
      .a_i(e13_a), .out_valid_o(e13_ovld[g]), .out_ready_i(e_ordy), .z_o(e13_z[g]),
      .ovf_o(e13_ovf[g]), .zero_o(e13_zero[g]));
  end

  // Output monitors: a transfer seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (a1_ovld && a_ordy) begin
      chk("a1_has_exp", 16'(q_a1.size() != 0), 16'd1);
      if (q_a1.size() != 0) chk("a1_out", pk(a1_zero, a1_ovf, 13'(a1_z)), q_a1.pop_front());
    end
    if (a2_ovld && a_ordy) begin
      chk("a2_has_exp", 16'(q_a2.size() != 0), 16'd1);
      if (q_a2.size() != 0) chk("a2_out", pk(a2_zero, a2_ovf, 13'(a2_z)), q_a2.pop_front());
    end
    if (b_ovld && b_ordy) begin
      b_nout++;
      chk("b_has_exp", 16'(q_b.size() != 0), 16'd1);
      if (q_b.size() != 0) chk("b_out", pk(b_zero, b_ovf, 13'(b_z)), q_b.pop_front());
    end
    if (c_ovld && c_ordy) begin
      c_nout++;
      chk("c_has_exp", 16'(q_c.size() != 0), 16'd1);
      if (q_c.size() != 0) chk("c_out", pk(c_zero, c_ovf, 13'(c_z)), q_c.pop_front());
    end
    if (d_ovld && d_ordy) begin
      chk("d_has_exp", 16'(q_d.size() != 0), 16'd1);
      if (q_d.size() != 0) chk("d_out", pk(d_zero, d_ovf, d_z), q_d.pop_front());
    end
  end

  task automatic send_a(input logic [1:0] op, input logic [7:0] a, input logic [7:0] z1,
                        input logic ovf1, input logic [7:0] z2, input logic ovf2);
    a_vld = 1'b1;
    a_op  = op;
    a_a   = a;
    q_a1.push_back(pk(z1 == 8'd0, ovf1, 13'(z1)));
    q_a2.push_back(pk(z2 == 8'd0, ovf2, 13'(z2)));
    for (int t = 0; t < 20 && !a1_irdy; t++) begin
      @(posedge clk);
      #1;
    end
    chk("a_in_ready", 16'(a1_irdy), 16'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, snap;
    rst_n = 1'b0;
    a_vld = 0; a_ordy = 1; a_op = 0; a_a = 0;
    b_vld = 0; b_ordy = 1; b_op = 0; b_a = 0;
    c_vld = 0; c_ordy = 1; c_op = 0; c_a = 0;
    d_vld = 0; d_ordy = 1; d_op = 0; d_a = 0;
    e_vld = 1; e_ordy = 1; e4_op = 0; e4_a = 0; e13_op = 0; e13_a = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_out_vld", 16'(a1_ovld), 16'd0);
    chk("rst_payload", pk(a1_zero, a1_ovf, 13'(a1_z)), pk(1'b0, 1'b0, 13'd0));
    chk("rst_in_rdy", 16'(a1_irdy), 16'd1);
    chk("rst_b_payload", pk(b_zero, b_ovf, 13'(b_z)), pk(1'b0, 1'b0, 13'd0));

    // Back-to-back basic ops, then overflow and zero edges.
    send_a(2'd2, 8'hF6, 8'h0A, 1'b0, 8'h0A, 1'b0);
    chk("latency_1", 16'(a1_ovld), 16'd1);
    send_a(2'd1, 8'h05, 8'hFB, 1'b0, 8'hFB, 1'b0);
    send_a(2'd0, 8'h80, 8'h80, 1'b0, 8'h80, 1'b0);
    send_a(2'd3, 8'h07, 8'hF9, 1'b0, 8'hF9, 1'b0);
    send_a(2'd2, 8'h80, 8'h80, 1'b1, 8'h7F, 1'b1);
    send_a(2'd1, 8'h80, 8'h80, 1'b1, 8'h7F, 1'b1);
    send_a(2'd3, 8'h80, 8'h80, 1'b0, 8'h80, 1'b0);
    send_a(2'd1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    send_a(2'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    send_a(2'd2, 8'hFF, 8'h01, 1'b0, 8'h01, 1'b0);
    send_a(2'd3, 8'h7F, 8'h81, 1'b0, 8'h81, 1'b0);
    a_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("a1_drained", 16'(q_a1.size()), 16'd0);
    chk("a2_drained", 16'(q_a2.size()), 16'd0);

    // Backpressure on a three-deep pipe: ABS of -1..-6, sink stalled for four cycles.
    nb = 1;
    b_vld = 1'b1;
    b_op  = 2'd2;
    for (int c = 0; c < 7; c++) begin
      b_ordy = (c < 3);
      b_a    = 8'(0 - nb);
      @(negedge clk);
      if (c >= 3) begin
        chk("bp_stall_vld", 16'(b_ovld), 16'd1);
        chk("bp_stall_z", 16'(b_z), 16'd1);
        chk("bp_stall_rdy", 16'(b_irdy), 16'd0);
      end
      if (b_irdy) begin
        q_b.push_back(pk(1'b0, 1'b0, 13'(nb)));
        nb++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", 16'(nb - 1), 16'd3);
    b_ordy = 1'b1;
    for (int c = 0; c < 20 && nb <= 6; c++) begin
      b_a = 8'(0 - nb);
      @(negedge clk);
      if (b_irdy) begin
        q_b.push_back(pk(1'b0, 1'b0, 13'(nb)));
        nb++;
      end
      @(posedge clk);
      #1;
    end
    b_vld = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("bp_out_count", 16'(b_nout), 16'd6);
    chk("bp_drained", 16'(q_b.size()), 16'd0);

    // Reset with two results in flight: they must vanish.
    c_ordy = 1'b0;
    c_vld  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      c_op = (c == 0) ? 2'd1 : 2'd2;
      c_a  = (c == 0) ? 8'h03 : 8'hF0;
      @(negedge clk);
      if (c_irdy) q_c.push_back(model(8, 1'b0, c_op, 13'(c_a)));
      @(posedge clk);
      #1;
    end
    c_vld = 1'b0;
    chk("rst_inflight_vld", 16'(c_ovld), 16'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_c.delete();
    chk("rst_mid_vld", 16'(c_ovld), 16'd0);
    chk("rst_mid_z", 16'(c_z), 16'd0);
    chk("rst_mid_rdy", 16'(c_irdy), 16'd1);
    snap   = c_nout;
    c_ordy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_stale", 16'(c_nout - snap), 16'd0);

    // Random sweep with random valid and ready on the two-stage pipes.
    for (int n = 0; n < 800; n++) begin
      c_vld  = ($urandom_range(0, 3) != 0);
      c_op   = 2'($urandom);
      c_a    = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      c_ordy = ($urandom_range(0, 3) != 0);
      d_vld  = ($urandom_range(0, 3) != 0);
      d_op   = 2'($urandom);
      d_a    = ($urandom_range(0, 7) == 0) ? 13'h1000 : 13'($urandom);
      d_ordy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (c_vld && c_irdy) q_c.push_back(model(8, 1'b0, c_op, 13'(c_a)));
      if (d_vld && d_irdy) q_d.push_back(model(13, 1'b0, d_op, d_a));
      @(posedge clk);
      #1;
    end
    c_vld = 0; d_vld = 0; c_ordy = 1; d_ordy = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("c_drained", 16'(q_c.size()), 16'd0);
    chk("d_drained", 16'(q_d.size()), 16'd0);

    // Combinational variants: exhaustive Width 4, random Width 13.
    for (int op = 0; op < 4; op++) begin
      for (int v = 0; v < 16; v++) begin
        e4_op = 2'(op);
        e4_a  = 4'(v);
        #1;
        for (int s = 0; s < 4; s++)
          chk("w4_sweep", pk(e4_zero[s], e4_ovf[s], 13'(e4_z[s])),
              model(4, s == 3, 2'(op), 13'(v)));
      end
    end
    for (int n = 0; n < 300; n++) begin
      e13_op = 2'($urandom);
      e13_a  = ($urandom_range(0, 9) == 0) ? 13'h1000 : 13'($urandom);
      #1;
      for (int s = 0; s < 3; s++)
        chk("w13_sweep", pk(e13_zero[s], e13_ovf[s], e13_z[s]), model(13, 1'b0, e13_op, e13_a));
    end
    e_vld  = 1'b0;
    e_ordy = 1'b0;
    #1;
    chk("comb_vld_low", 16'(e4_ovld[1]), 16'd0);
    chk("comb_rdy_low", 16'(e13_irdy[2]), 16'd0);
    e_vld  = 1'b1;
    e_ordy = 1'b1;
    #1;
    chk("comb_vld_high", 16'(e13_ovld[0]), 16'd1);
    chk("comb_rdy_high", 16'(e4_irdy[2]), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
